demuxn_buf: RTL and testbench

- N-bit, 1-to-2 registered demultiplexer with valid/ready handshake. It is the routing counterpart of the N-bit 2-to-1 mux.
- Each input word is steered to output channel A or B by `sel` and held in a one-entry buffer per channel until that channel's consumer accepts it.
- It sits between a single producer and two consumers, for example an ALU result bus fanned out to two register targets.
- A per-channel wrap-around count of accepted words is exposed for debug and verification.

---
 rtl/demuxn_buf.sv | 87 ++++++++
 tb/tb_demuxn_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demuxn_buf.sv
// 1-to-2 registered demultiplexer: each word is steered by in_sel into a
// one-entry buffer on channel A or B, with a per-channel accepted-word count.
module demuxn_chan #(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [N-1:0]  load_data,
    input  logic          ready,
    output logic [N-1:0]  data,
    output logic          valid,
    output logic [CW-1:0] count
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            // A load always leaves the buffer FULL, even when it drains in the same cycle
            state <= FULL;
            data  <= load_data;
            count <= count + 1'b1;
        end else if (state == FULL && ready) begin
            state <= EMPTY;
        end
    end

    assign valid = (state == FULL);
endmodule

module demuxn_buf #(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  a_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [N-1:0]  b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);
    logic accept;
    logic load_a;
    logic load_b;

    // Held low in reset so no producer handshake completes while state is discarded
    assign in_ready = rst_n && (in_sel ? (!b_valid || b_ready) : (!a_valid || a_ready));
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && !in_sel;
    assign load_b   = accept && in_sel;

    demuxn_chan #(.N(N), .CW(CW)) u_chan_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .ready     (a_ready),
        .data      (a_data),
        .valid     (a_valid),
        .count     (a_count)
    );

    demuxn_chan #(.N(N), .CW(CW)) u_chan_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .ready     (b_ready),
        .data      (b_data),
        .valid     (b_valid),
        .count     (b_count)
    );
endmodule

// File: tb/tb_demuxn_buf.sv
// Scoreboard bench for demuxn_buf: accepted words are queued per channel and
// a negedge monitor compares every drained word against the queue head.
module tb_demuxn_buf;
    localparam int N  = 32;
    localparam int CW = 8;

    logic          clk = 0;
    logic          rst_n;
    logic [N-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [N-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];

    demuxn_buf #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted (bounded wait).
    task automatic send(input logic [N-1:0] d, input logic sel);
        bit done = 0;
        in_data  = d;
        in_sel   = sel;
        in_valid = 1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sel) qb.push_back(d); else qa.push_back(d);
                done = 1;
            end
            tick();
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 0;
    endtask

    // Monitor: every drained word must match the head of its channel queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) chk("a_unexpected", a_data, 32'hx);
                else chk("a_drain", a_data, qa.pop_front());
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) chk("b_unexpected", b_data, 32'hx);
                else chk("b_drain", b_data, qb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 1; in_data = 32'hAAAA_AAAA; in_sel = 0;
        a_ready = 0; b_ready = 0;
        tick(); tick();
        @(negedge clk);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        tick();
        rst_n = 1; in_valid = 0;
        tick();
        @(negedge clk);
        chk("post_rst_a_valid", a_valid, 0);
        chk("post_rst_a_count", a_count, 0);

        // Single route to B
        tick();
        send(32'hDEAD_BEEF, 1);
        @(negedge clk);
        chk("single_b_valid", b_valid, 1);
        chk("single_b_data", b_data, 32'hDEAD_BEEF);
        chk("single_a_valid", a_valid, 0);
        chk("single_b_count", b_count, 1);
        tick();
        b_ready = 1;
        tick();
        b_ready = 0;
        @(negedge clk);
        chk("single_b_drained", b_valid, 0);

        // Full throughput to A
        tick();
        a_ready = 1; in_sel = 0; in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            in_data = i;
            @(negedge clk);
            chk("tp_in_ready", in_ready, 1);
            qa.push_back(i);
            tick();
        end
        in_valid = 0;
        tick();
        @(negedge clk);
        chk("tp_a_count", a_count, 16);
        chk("tp_a_empty", a_valid, 0);

        // Backpressure on A
        tick();
        a_ready = 0;
        send(32'h11, 0);
        in_data = 32'h22; in_sel = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_a_data", a_data, 32'h11);
            chk("bp_a_valid", a_valid, 1);
            tick();
        end
        a_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        qa.push_back(32'h22);
        tick();
        in_valid = 0; a_ready = 0;
        @(negedge clk);
        chk("bp_a_data_new", a_data, 32'h22);
        chk("bp_a_valid_new", a_valid, 1);
        chk("bp_a_count", a_count, 18);

        // Cross-channel: A stalled, B still accepts
        tick();
        in_data = 32'h33; in_sel = 1; in_valid = 1;
        @(negedge clk);
        chk("x_in_ready", in_ready, 1);
        qb.push_back(32'h33);
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("x_b_data", b_data, 32'h33);
        chk("x_b_valid", b_valid, 1);
        chk("x_a_data_held", a_data, 32'h22);
        chk("x_a_valid_held", a_valid, 1);
        // A drains while B drains and reloads in the same cycle
        tick();
        a_ready = 1; b_ready = 1; in_data = 32'h44; in_sel = 1; in_valid = 1;
        @(negedge clk);
        chk("x2_in_ready", in_ready, 1);
        qb.push_back(32'h44);
        tick();
        in_valid = 0; a_ready = 0; b_ready = 0;
        @(negedge clk);
        chk("x2_a_valid", a_valid, 0);
        chk("x2_a_data_hold", a_data, 32'h22);
        chk("x2_b_valid", b_valid, 1);
        chk("x2_b_data", b_data, 32'h44);
        chk("x2_b_count", b_count, 3);
        tick();
        b_ready = 1;
        tick();
        b_ready = 0;

        // Counter wrap on B from a fresh reset
        rst_n = 0;
        tick();
        rst_n = 1;
        qa.delete(); qb.delete();
        @(negedge clk);
        chk("wrap_start_count", b_count, 0);
        tick();
        b_ready = 1; in_sel = 1; in_valid = 1;
        for (int i = 0; i < 257; i++) begin
            in_data = 32'h1000 + i;
            @(negedge clk);
            if (i == 255) chk("wrap_pre_count", b_count, 255);
            if (i == 256) chk("wrap_zero_count", b_count, 0);
            if (!in_ready) chk("wrap_in_ready", in_ready, 1);
            qb.push_back(32'h1000 + i);
            tick();
        end
        in_valid = 0;
        tick();
        b_ready = 0;
        @(negedge clk);
        chk("wrap_b_count", b_count, 1);

        // Mid-operation reset with both channels FULL
        tick();
        send(32'h55, 0);
        send(32'h66, 1);
        @(negedge clk);
        chk("mid_both_full", {a_valid, b_valid}, 2'b11);
        tick();
        rst_n = 0;
        tick();
        @(negedge clk);
        chk("mid_a_valid", a_valid, 0);
        chk("mid_b_valid", b_valid, 0);
        chk("mid_a_count", a_count, 0);
        chk("mid_b_count", b_count, 0);
        chk("mid_a_data", a_data, 0);
        qa.delete(); qb.delete();
        tick();
        rst_n = 1;
        tick();

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
